// File: rtl/gate_bist_ctrl.sv
// gate_bist_ctrl: built-in self-test sequencer for the two-input basic-gate block.
// Walks {a,b} through 00, 01, 10, 11. Each vector is held for the settle time and
// then sampled once. The {xor,nand,not,or,and} outputs are checked against golden
// values, and per-vector, per-gate and total mismatch results are accumulated.
module gate_bist_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       a_out,
    output logic       b_out,
    input  logic [4:0] gates_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_vec,
    output logic [4:0] fail_mask,
    output logic [4:0] err_count
);

    // A settle time of zero would skip APPLY altogether, so it is clamped to one cycle.
    localparam int unsigned SETTLE_EFF = (SETTLE_CYCLES == 0) ? 1 : SETTLE_CYCLES;
    localparam logic [7:0]  CNT_LAST   = 8'(SETTLE_EFF - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_APPLY,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [7:0] cnt_q, cnt_d;
    logic       pass_q, pass_d;
    logic [3:0] fail_vec_q, fail_vec_d;
    logic [4:0] fail_mask_q, fail_mask_d;
    logic [4:0] err_count_q, err_count_d;
    logic [4:0] mism;

    // Golden response of a good gate block. Packing is {xor,nand,not,or,and}, and not = ~a.
    function automatic logic [4:0] golden(input logic [1:0] ab);
        logic [4:0] g;
        case (ab)
            2'b00:   g = 5'b01100;
            2'b01:   g = 5'b11110;
            2'b10:   g = 5'b11010;
            default: g = 5'b00011;
        endcase
        return g;
    endfunction

    function automatic logic [2:0] popcount5(input logic [4:0] m);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < 5; i++) begin
            n = n + 3'(m[i]);
        end
        return n;
    endfunction

    // gates_in only matters in SAMPLE. In every other state this difference is ignored.
    assign mism = gates_in ^ golden(idx_q);

    // State register with synchronous reset. A reset in the middle of a run simply abandons it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            pass_q      <= 1'b0;
            fail_vec_q  <= '0;
            fail_mask_q <= '0;
            err_count_q <= '0;
        end else begin
            // NOTE: non-blocking assignments make every register here update from the
            // pre-edge values, so the order of these lines has no effect.
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            pass_q      <= pass_d;
            fail_vec_q  <= fail_vec_d;
            fail_mask_q <= fail_mask_d;
            err_count_q <= err_count_d;
        end
    end

    // Next-state logic: sequence the vectors, time the settle window and accumulate results.
    always_comb begin
        // NOTE: every signal driven here gets a default first. A path that leaves one
        // unassigned would infer a latch.
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        pass_d      = pass_q;
        fail_vec_d  = fail_vec_q;
        fail_mask_d = fail_mask_q;
        err_count_d = err_count_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_APPLY;
                    idx_d       = '0;
                    cnt_d       = '0;
                    pass_d      = 1'b0;
                    fail_vec_d  = '0;
                    fail_mask_d = '0;
                    err_count_d = '0;
                end
            end
            S_APPLY: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                fail_vec_d[idx_q] = |mism;
                fail_mask_d       = fail_mask_q | mism;
                err_count_d       = err_count_q + 5'(popcount5(mism));
                if (idx_q == 2'd3) begin
                    state_d = S_DONE;
                    pass_d  = (err_count_d == 5'd0);
                end else begin
                    state_d = S_APPLY;
                    idx_d   = idx_q + 2'd1;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from registered state only, so a_out and b_out are glitch-free
    // and stay stable for the whole vector.
    assign busy      = (state_q == S_APPLY) || (state_q == S_SAMPLE);
    assign done      = (state_q == S_DONE);
    assign a_out     = busy & idx_q[1];
    assign b_out     = busy & idx_q[0];
    assign pass      = pass_q;
    assign fail_vec  = fail_vec_q;
    assign fail_mask = fail_mask_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// tb_gate_bist_ctrl: exercises three controllers (settle 2, 3 and 0) that share the same
// clock, reset and start. Each one drives a behavioural gate block. The gate block of the
// settle-2 unit can have stuck-at and inversion faults injected, and the table rows
// describe these faults together with the hand-computed results expected for each.
module tb_gate_bist_ctrl;

    localparam int WINDOW = 22;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       a_o       [3];
    logic       b_o       [3];
    logic [4:0] gates_w   [3];
    logic       busy_o    [3];
    logic       done_o    [3];
    logic       pass_o    [3];
    logic [3:0] fail_vec_o[3];
    logic [4:0] fail_mask_o[3];
    logic [4:0] err_count_o[3];

    // Fault controls for the gate block on unit 0: invert, force-0, force-1 masks.
    logic [4:0] f_inv, f_sa0, f_sa1;

    // Effective settle cycles of each unit
    int s_eff [3] = '{2, 3, 1};

    int n_vec  = 0;
    int n_miss = 0;

    int   first_done [3];
    int   n_done     [3];
    int   wave_bad   [3];
    logic busy_hist  [0:WINDOW];

    typedef struct {
        logic [4:0] inv;
        logic [4:0] sa0;
        logic [4:0] sa1;
        logic       pass;
        logic [3:0] fv;
        logic [4:0] fm;
        int         ec;
    } vec_t;

    vec_t tbl [8];

    // Gate-level reference of a healthy gate block, packed as {xor,nand,not,or,and}.
    function automatic logic [4:0] gate_model(input logic a, input logic b);
        return {a ^ b, ~(a & b), ~a, a | b, a & b};
    endfunction

    assign gates_w[0] = ((gate_model(a_o[0], b_o[0]) ^ f_inv) & ~f_sa0) | f_sa1;
    assign gates_w[1] = gate_model(a_o[1], b_o[1]);
    assign gates_w[2] = gate_model(a_o[2], b_o[2]);

    gate_bist_ctrl #(.SETTLE_CYCLES(2)) u_dut_s2 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .a_out(a_o[0]), .b_out(b_o[0]), .gates_in(gates_w[0]),
        .busy(busy_o[0]), .done(done_o[0]), .pass(pass_o[0]),
        .fail_vec(fail_vec_o[0]), .fail_mask(fail_mask_o[0]), .err_count(err_count_o[0])
    );

    gate_bist_ctrl #(.SETTLE_CYCLES(3)) u_dut_s3 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .a_out(a_o[1]), .b_out(b_o[1]), .gates_in(gates_w[1]),
        .busy(busy_o[1]), .done(done_o[1]), .pass(pass_o[1]),
        .fail_vec(fail_vec_o[1]), .fail_mask(fail_mask_o[1]), .err_count(err_count_o[1])
    );

    gate_bist_ctrl #(.SETTLE_CYCLES(0)) u_dut_s0 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .a_out(a_o[2]), .b_out(b_o[2]), .gates_in(gates_w[2]),
        .busy(busy_o[2]), .done(done_o[2]), .pass(pass_o[2]),
        .fail_vec(fail_vec_o[2]), .fail_mask(fail_mask_o[2]), .err_count(err_count_o[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_row(input int i, input logic [4:0] inv, input logic [4:0] sa0,
                           input logic [4:0] sa1, input logic p, input logic [3:0] fv,
                           input logic [4:0] fm, input int ec);
        tbl[i].inv  = inv;
        tbl[i].sa0  = sa0;
        tbl[i].sa1  = sa1;
        tbl[i].pass = p;
        tbl[i].fv   = fv;
        tbl[i].fm   = fm;
        tbl[i].ec   = ec;
    endtask

    // Pulse start into edge E, then observe cycles E+1 .. E+WINDOW. Cycle E+k is sampled
    // 1 time unit after the k-th edge counted from E. For each unit this records the first
    // done cycle, the number of done pulses, and deviations of a/b/busy from the nominal
    // vector timeline.
    task automatic run_test(input int repulse_k, input bit hold);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        for (int d = 0; d < 3; d++) begin
            first_done[d] = 0;
            n_done[d]     = 0;
            wave_bad[d]   = 0;
        end
        for (int k = 1; k <= WINDOW; k++) begin
            busy_hist[k] = busy_o[0];
            for (int d = 0; d < 3; d++) begin
                int period = s_eff[d] + 1;
                int last   = 4 * period;
                if (done_o[d] === 1'b1) begin
                    n_done[d]++;
                    if (first_done[d] == 0) first_done[d] = k;
                end
                if (k <= last) begin
                    int         vi     = (k - 1) / period;
                    logic [1:0] exp_ab = vi[1:0];
                    if ({a_o[d], b_o[d]} !== exp_ab || busy_o[d] !== 1'b1 || done_o[d] !== 1'b0)
                        wave_bad[d]++;
                end else if (k == last + 1) begin
                    if ({a_o[d], b_o[d]} !== 2'b00 || busy_o[d] !== 1'b0)
                        wave_bad[d]++;
                end
            end
            if (repulse_k > 0 && k == repulse_k)     start = 1'b1;
            if (repulse_k > 0 && k == repulse_k + 1) start = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_timing(input string tag, input bit check_count);
        int exp_done [3] = '{13, 17, 9};
        for (int d = 0; d < 3; d++) begin
            check($sformatf("%s done_cycle u%0d", tag, d), first_done[d], exp_done[d]);
            check($sformatf("%s ab_busy_wave u%0d", tag, d), wave_bad[d], 0);
            if (check_count)
                check($sformatf("%s done_pulses u%0d", tag, d), n_done[d], 1);
        end
    endtask

    task automatic check_clean_results(input string tag);
        for (int d = 1; d < 3; d++) begin
            check($sformatf("%s pass u%0d", tag, d), pass_o[d], 1'b1);
            check($sformatf("%s err_count u%0d", tag, d), err_count_o[d], 0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        f_inv = '0;
        f_sa0 = '0;
        f_sa1 = '0;

        //         inv       sa0       sa1       pass  fail_vec  fail_mask err
        set_row(0, 5'b00000, 5'b00000, 5'b00000, 1'b1, 4'b0000, 5'b00000, 0);  // healthy
        set_row(1, 5'b00000, 5'b00001, 5'b00000, 1'b0, 4'b1000, 5'b00001, 1);  // and s-a-0
        set_row(2, 5'b10000, 5'b00000, 5'b00000, 1'b0, 4'b1111, 5'b10000, 4);  // xor inverted
        set_row(3, 5'b00000, 5'b00000, 5'b00010, 1'b0, 4'b0001, 5'b00010, 1);  // or s-a-1
        set_row(4, 5'b00000, 5'b00100, 5'b00000, 1'b0, 4'b0011, 5'b00100, 2);  // not s-a-0
        set_row(5, 5'b11111, 5'b00000, 5'b00000, 1'b0, 4'b1111, 5'b11111, 20); // all inverted
        set_row(6, 5'b00000, 5'b00000, 5'b01000, 1'b0, 4'b1000, 5'b01000, 1);  // nand s-a-1
        set_row(7, 5'b00000, 5'b10000, 5'b00001, 1'b0, 4'b0111, 5'b10001, 5);  // xor s-a-0 + and s-a-1

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset a/b", {a_o[0], b_o[0]}, 2'b00);
        check("reset busy/done", {busy_o[0], done_o[0]}, 2'b00);
        check("reset pass", pass_o[0], 1'b0);
        check("reset fail_vec", fail_vec_o[0], 4'b0000);
        check("reset fail_mask", fail_mask_o[0], 5'b00000);
        check("reset err_count", err_count_o[0], 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Fault table
        for (int r = 0; r < 8; r++) begin
            f_inv = tbl[r].inv;
            f_sa0 = tbl[r].sa0;
            f_sa1 = tbl[r].sa1;
            run_test(0, 1'b0);
            check_timing($sformatf("row%0d", r), 1'b1);
            check($sformatf("row%0d pass", r), pass_o[0], tbl[r].pass);
            check($sformatf("row%0d fail_vec", r), fail_vec_o[0], tbl[r].fv);
            check($sformatf("row%0d fail_mask", r), fail_mask_o[0], tbl[r].fm);
            check($sformatf("row%0d err_count", r), err_count_o[0], tbl[r].ec);
            check_clean_results($sformatf("row%0d", r));
        end

        // Start re-pulsed during APPLY of vector 2 (cycle E+7) must be ignored
        f_inv = 5'b10000;
        f_sa0 = '0;
        f_sa1 = '0;
        run_test(7, 1'b0);
        check_timing("repulse", 1'b1);
        check("repulse fail_vec", fail_vec_o[0], 4'b1111);
        check("repulse err_count", err_count_o[0], 4);

        // Reset during SAMPLE of vector 1 (cycle E+6)
        f_inv = 5'b11111;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("pre-reset ab vec1", {a_o[0], b_o[0], busy_o[0]}, 3'b011);
        check("pre-reset err_count", err_count_o[0], 5);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("midrun reset outputs",
              {a_o[0], b_o[0], busy_o[0], done_o[0], pass_o[0], fail_vec_o[0], fail_mask_o[0], err_count_o[0]},
              '0);
        begin
            int dn = 0;
            for (int k = 0; k < 20; k++) begin
                if (done_o[0] === 1'b1 || done_o[1] === 1'b1 || done_o[2] === 1'b1) dn++;
                @(posedge clk);
                #1;
            end
            check("no done after reset", dn, 0);
        end
        f_inv = '0;
        run_test(0, 1'b0);
        check_timing("post-reset", 1'b1);
        check("post-reset pass", pass_o[0], 1'b1);
        check("post-reset err_count", err_count_o[0], 0);

        // Start held high: second run accepted on the first IDLE cycle after DONE
        run_test(0, 1'b1);
        check_timing("hold", 1'b0);
        check("hold busy idle cycle", busy_hist[14], 1'b0);
        check("hold busy restart", busy_hist[15], 1'b1);
        start = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("hold second run pass", pass_o[0], 1'b1);
        check("hold idle after drain", busy_o[0], 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
